my_interp_gate: RTL and testbench

Linear-interpolating upsampler that sits downstream of the gated moving-average decimator. It accepts the decimated output stream, one sample per `DIV_FACTOR` trigger periods, and regenerates a sample on every fast `trig`. Between two consecutive decimated samples it ramps linearly, so the DAC/feedback path gets a smooth full-rate signal. It forms the expansion end of the decimate/expand pair and is parameterised with the same `DIV_FACTOR` as the decimator.

---
 rtl/my_interp_gate_if.sv | 22 ++
 rtl/my_interp_gate.sv | 166 ++++++++++++++++
 tb/tb_my_interp_gate.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/my_interp_gate_if.sv
// Stream bundle between the decimated sample source, the fast trigger and
// the interpolating upsampler. The master drives strobes and samples; the
// slave (the upsampler) returns the full-rate stream and its status.
interface my_interp_gate_if;
    logic               trig;
    logic               din_valid;
    logic signed [31:0] din;
    logic signed [31:0] dout;
    logic               dout_valid;
    logic signed [31:0] monitor_step;
    logic               underrun;

    modport master (
        output trig, din_valid, din,
        input  dout, dout_valid, monitor_step, underrun
    );

    modport slave (
        input  trig, din_valid, din,
        output dout, dout_valid, monitor_step, underrun
    );
endinterface

// File: rtl/my_interp_gate.sv
// Linear-interpolating upsampler: expands a decimated stream back to the
// fast trigger rate by ramping from the previous sample to the newest one
// over DIV_FACTOR triggers. The ramp is kept in a fixed-point accumulator
// scaled by DIV_FACTOR so every output is an exact floor of the ideal line.
module my_interp_gate #(
    parameter int DIV_FACTOR = 4,
    parameter int DIV_LOG2   = $clog2(DIV_FACTOR)
) (
    input  logic            clk,
    input  logic            rst,
    my_interp_gate_if.slave bus
);

    localparam int DATA_W = 32;
    localparam int STEP_W = DATA_W + 1;
    localparam int ACC_W  = 34 + DIV_LOG2;
    localparam int PH_W   = DIV_LOG2 + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_RUN
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic signed [DATA_W-1:0]   r_prev;
    logic signed [DATA_W-1:0]   r_cur;
    logic signed [STEP_W-1:0]   r_step;
    logic signed [ACC_W-1:0]    r_acc;
    logic        [PH_W-1:0]     r_phase;
    logic signed [DATA_W-1:0]   r_dout_p1;
    logic                       r_vld_p1;
    logic signed [DATA_W-1:0]   r_mon_p1;
    logic                       r_underrun;

    logic                       w_load_first;
    logic                       w_seg_start;
    logic                       w_emit;
    logic signed [STEP_W-1:0]   w_step_new;

    // Place a sample on the accumulator grid (scaled by DIV_FACTOR).
    function automatic logic signed [ACC_W-1:0] f_align(input logic signed [DATA_W-1:0] x);
        logic signed [ACC_W-1:0] t;
        t = {{(ACC_W-DATA_W){x[DATA_W-1]}}, x};
        f_align = t <<< DIV_LOG2;
    endfunction

    // Sign-extend a segment step to accumulator width.
    function automatic logic signed [ACC_W-1:0] f_sext_step(input logic signed [STEP_W-1:0] s);
        f_sext_step = {{(ACC_W-STEP_W){s[STEP_W-1]}}, s};
    endfunction

    // Floor back to sample units; the ramp stays between prev and cur so
    // the result always fits DATA_W without saturation.
    function automatic logic signed [DATA_W-1:0] f_floor(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] t;
        t = a >>> DIV_LOG2;
        f_floor = DATA_W'(t);
    endfunction

    // Halved step for monitoring; a 33-bit step halved always fits 32 bits.
    function automatic logic signed [DATA_W-1:0] f_half(input logic signed [STEP_W-1:0] s);
        logic signed [STEP_W-1:0] t;
        t = s >>> 1;
        f_half = DATA_W'(t);
    endfunction

    // Full-precision difference between the incoming and the held sample.
    assign w_step_new = {bus.din[DATA_W-1], bus.din} - {r_cur[DATA_W-1], r_cur};

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and event decode: first sample loads, later samples start segments.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_first = 1'b0;
        w_seg_start  = 1'b0;
        w_emit       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load_first = bus.din_valid;
                if (bus.din_valid) begin
                    w_state_nxt = S_PRIME;
                end
            end
            S_PRIME: begin
                w_seg_start = bus.din_valid;
                w_emit      = bus.trig;
                if (bus.din_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_seg_start = bus.din_valid;
                w_emit      = bus.trig;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Sample, ramp and output registers; a new segment wins over a plain trigger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev     <= '0;
            r_cur      <= '0;
            r_step     <= '0;
            r_acc      <= '0;
            r_phase    <= '0;
            r_dout_p1  <= '0;
            r_vld_p1   <= 1'b0;
            r_mon_p1   <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_vld_p1 <= w_emit;
            r_mon_p1 <= f_half(r_step);
            if (w_load_first) begin
                r_prev <= bus.din;
                r_cur  <= bus.din;
            end else if (w_seg_start) begin
                r_prev <= r_cur;
                r_cur  <= bus.din;
                r_step <= w_step_new;
                if (bus.trig) begin
                    // The coincident trigger emits k=0 of the new segment.
                    r_dout_p1 <= r_cur;
                    r_acc     <= f_align(r_cur) + f_sext_step(w_step_new);
                    r_phase   <= PH_W'(1);
                end else begin
                    r_acc   <= f_align(r_cur);
                    r_phase <= '0;
                end
            end else if (bus.trig) begin
                if (r_state == S_PRIME) begin
                    r_dout_p1 <= r_cur;
                end else if (r_state == S_RUN) begin
                    if (r_phase < PH_W'(DIV_FACTOR)) begin
                        r_dout_p1 <= f_floor(r_acc);
                        r_acc     <= r_acc + f_sext_step(r_step);
                        r_phase   <= r_phase + PH_W'(1);
                    end else begin
                        // Segment outlasted its triggers: hold the endpoint.
                        r_dout_p1  <= r_cur;
                        r_underrun <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.dout         = r_dout_p1;
    assign bus.dout_valid   = r_vld_p1;
    assign bus.monitor_step = r_mon_p1;
    assign bus.underrun     = r_underrun;

endmodule

// File: tb/tb_my_interp_gate.sv
// Directed bench for my_interp_gate (DIV_FACTOR = 4): table-driven ramp
// vectors plus hand-written reset, prime and coincident-event sequences.
module tb_my_interp_gate;

    logic clk = 1'b0;
    logic rst = 1'b1;

    my_interp_gate_if bus ();

    my_interp_gate #(.DIV_FACTOR(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0]       a;
        logic [31:0]       b;
        logic [3:0]        ntrig;
        logic [5:0][31:0]  exp;
        logic [31:0]       mon;
        logic [3:0]        urun_at;
    } vec_t;

    vec_t vecs [5];

    function automatic vec_t mk(int a, int b, int n, int e0, int e1, int e2,
                                int e3, int e4, int e5, int mon, int u);
        vec_t v;
        v.a       = a;
        v.b       = b;
        v.ntrig   = 4'(n);
        v.exp[0]  = e0;
        v.exp[1]  = e1;
        v.exp[2]  = e2;
        v.exp[3]  = e3;
        v.exp[4]  = e4;
        v.exp[5]  = e5;
        v.mon     = mon;
        v.urun_at = 4'(u);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_reset();
        rst           = 1'b1;
        bus.trig      = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [31:0] v);
        @(posedge clk); #1;
        bus.din       = v;
        bus.din_valid = 1'b1;
        @(posedge clk); #1;
        bus.din_valid = 1'b0;
    endtask

    task automatic trig_chk(input string name, input logic [31:0] exp);
        bus.trig = 1'b1;
        @(posedge clk); #1;
        bus.trig = 1'b0;
        check({name, ".valid"}, {31'd0, bus.dout_valid}, 32'd1);
        check({name, ".dout"}, bus.dout, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(0, 400, 4, 0, 100, 200, 300, 0, 0, 200, 0);
        vecs[1] = mk(100, -300, 4, 100, 0, -100, -200, 0, 0, -200, 0);
        vecs[2] = mk(0, 3, 4, 0, 0, 1, 2, 0, 0, 1, 0);
        vecs[3] = mk(0, 400, 6, 0, 100, 200, 300, 400, 400, 200, 5);
        vecs[4] = mk(32'h7FFFFFFF, 32'h80000000, 4, 2147483647, 1073741823, -1,
                     -1073741825, 0, 0, 32'h80000000, 0);

        // Reset aborts mid-segment; IDLE ignores triggers.
        do_reset();
        send(32'd0);
        send(32'd400);
        trig_chk("pre_rst", 32'd0);
        rst = 1'b1;
        #1;
        check("rst_async.dout", bus.dout, 32'd0);
        check("rst_async.mon", bus.monitor_step, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.trig = 1'b1;
            @(posedge clk); #1;
            bus.trig = 1'b0;
            check("idle.valid", {31'd0, bus.dout_valid}, 32'd0);
            check("idle.dout", bus.dout, 32'd0);
            check("idle.mon", bus.monitor_step, 32'd0);
            check("idle.urun", {31'd0, bus.underrun}, 32'd0);
        end

        // After reset a new sample restarts from IDLE into PRIME.
        send(32'd7);
        trig_chk("prime", 32'd7);
        @(posedge clk); #1;
        check("prime.pulse", {31'd0, bus.dout_valid}, 32'd0);

        // Table-driven ramp vectors.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            send(vecs[v].a);
            send(vecs[v].b);
            for (int k = 0; k < int'(vecs[v].ntrig); k++) begin
                trig_chk($sformatf("vec%0d.k%0d", v, k), vecs[v].exp[k]);
                check($sformatf("vec%0d.k%0d.urun", v, k), {31'd0, bus.underrun},
                      (vecs[v].urun_at != 0 && k + 1 >= int'(vecs[v].urun_at)) ? 32'd1 : 32'd0);
            end
            check($sformatf("vec%0d.mon", v), bus.monitor_step, vecs[v].mon);
            @(posedge clk); #1;
            check($sformatf("vec%0d.pulse", v), {31'd0, bus.dout_valid}, 32'd0);
        end

        // Sample arriving together with a trigger truncates the segment.
        do_reset();
        send(32'd0);
        send(32'd400);
        trig_chk("sim.k0", 32'd0);
        trig_chk("sim.k1", 32'd100);
        bus.din       = 32'd800;
        bus.din_valid = 1'b1;
        bus.trig      = 1'b1;
        @(posedge clk); #1;
        bus.din_valid = 1'b0;
        bus.trig      = 1'b0;
        check("sim.both.valid", {31'd0, bus.dout_valid}, 32'd1);
        check("sim.both.dout", bus.dout, 32'd400);
        trig_chk("sim.n1", 32'd500);
        trig_chk("sim.n2", 32'd600);
        trig_chk("sim.n3", 32'd700);
        check("sim.urun", {31'd0, bus.underrun}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
